// File: rtl/path_streamer_if.sv
// Coordinate stream carrying visited maze cells from the streamer to its consumer.
interface path_streamer_if #(
  parameter int N = 4
);
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_x;
  logic [N-1:0] out_y;
  logic         out_last;

  modport master (
    output out_valid,
    output out_x,
    output out_y,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_x,
    input  out_y,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/path_streamer.sv
// Path streamer: snapshots a solved maze visited-cell map on the rising edge
// of done and emits the coordinates of every set cell in row-major order over
// a valid/ready stream, flagging the final set cell with out_last.
module path_streamer #(
  parameter int size = 9,
  parameter int N    = 4,
  parameter int CW   = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [size-1:0][size-1:0]   path,
  input  logic                        done,
  path_streamer_if.master             out,
  output logic                        busy,
  output logic                        finished,
  output logic [CW-1:0]               cell_count
);

  localparam int              CELLS     = size * size;
  localparam logic [N-1:0]    LAST_C    = N'(size - 1);
  localparam logic [CW-1:0]   MAX_COUNT = CW'(CELLS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    EMIT   = 2'd2,
    FINISH = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              done_q, done_d;
  logic [CELLS-1:0]  snap_q, snap_d;
  logic [N-1:0]      x_q, x_d;
  logic [N-1:0]      y_q, y_d;
  logic              valid_q, valid_d;
  logic [N-1:0]      ox_q, ox_d;
  logic [N-1:0]      oy_q, oy_d;
  logic              last_q, last_d;
  logic [CW-1:0]     count_q, count_d;

  logic [CW-1:0]     idx_s;
  logic [CW:0]       shamt_s;
  logic              cur_bit_s;
  logic              later_s;
  logic              at_end_s;
  logic [N-1:0]      nx_s;
  logic [N-1:0]      ny_s;

  // Scan-index helpers: flat cell index, current bit, any set bit further on, next index.
  always_comb begin
    idx_s     = CW'(y_q) * CW'(size) + CW'(x_q);
    shamt_s   = {1'b0, idx_s} + {{CW{1'b0}}, 1'b1};
    cur_bit_s = snap_q[idx_s];
    later_s   = |(snap_q >> shamt_s);
    at_end_s  = (x_q == LAST_C) && (y_q == LAST_C);
    if (x_q == LAST_C) begin
      nx_s = '0;
      ny_s = y_q + N'(1);
    end else begin
      nx_s = x_q + N'(1);
      ny_s = y_q;
    end
  end

  // Next-state and datapath decisions; everything holds unless a state changes it.
  always_comb begin
    state_d = state_q;
    done_d  = done;
    snap_d  = snap_q;
    x_d     = x_q;
    y_d     = y_q;
    valid_d = valid_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    last_d  = last_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        // Only a fresh rising edge of done starts a stream.
        if (done && !done_q) begin
          snap_d  = path;
          count_d = '0;
          x_d     = '0;
          y_d     = '0;
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (cur_bit_s) begin
          valid_d = 1'b1;
          ox_d    = x_q;
          oy_d    = y_q;
          last_d  = !later_s;
          state_d = EMIT;
        end else if (at_end_s) begin
          state_d = FINISH;
        end else begin
          x_d = nx_s;
          y_d = ny_s;
        end
      end
      EMIT: begin
        if (out.out_ready) begin
          valid_d = 1'b0;
          // Saturate so the count can never wrap even if parameters are stretched.
          count_d = (count_q == MAX_COUNT) ? count_q : count_q + CW'(1);
          if (at_end_s) begin
            state_d = FINISH;
          end else begin
            x_d     = nx_s;
            y_d     = ny_s;
            state_d = SCAN;
          end
        end else begin
          state_d = EMIT;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      snap_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      ox_q    <= '0;
      oy_q    <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      snap_q  <= snap_d;
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  assign out.out_valid = valid_q;
  assign out.out_x     = ox_q;
  assign out.out_y     = oy_q;
  assign out.out_last  = last_q;
  assign busy          = (state_q != IDLE);
  assign finished      = (state_q == FINISH);
  assign cell_count    = count_q;

endmodule

// File: tb/tb_path_streamer.sv
// Bench for path_streamer: table of maze maps with expected cell counts plus
// hand-written stall / reset / restart sequences; a scoreboard queue holds the
// expected coordinates and is popped on every accepted handshake.
module tb_path_streamer;

  localparam int SIZE = 9;
  localparam int N    = 4;
  localparam int CW   = 7;

  typedef logic [SIZE-1:0][SIZE-1:0] map_t;

  typedef struct {
    map_t map;
    int   exp_count;
    bit   rnd_ready;
  } vec_t;

  typedef struct {
    int x;
    int y;
    bit last;
  } cell_t;

  logic          clk;
  logic          rst;
  map_t          path;
  logic          done;
  logic          busy;
  logic          finished;
  logic [CW-1:0] cell_count;

  int n_cmp;
  int n_bad;
  int valid_cycles;
  cell_t exp_q[$];
  vec_t vecs[6];

  path_streamer_if #(.N(N)) sif ();

  path_streamer #(.size(SIZE), .N(N), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .path       (path),
    .done       (done),
    .out        (sif),
    .busy       (busy),
    .finished   (finished),
    .cell_count (cell_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: every set cell in row-major order, last flag on the final one.
  task automatic push_expected(input map_t m);
    int last_idx;
    cell_t c;
    last_idx = -1;
    for (int y = 0; y < SIZE; y++)
      for (int x = 0; x < SIZE; x++)
        if (m[y][x]) last_idx = y * SIZE + x;
    for (int y = 0; y < SIZE; y++)
      for (int x = 0; x < SIZE; x++)
        if (m[y][x]) begin
          c.x = x;
          c.y = y;
          c.last = ((y * SIZE + x) == last_idx);
          exp_q.push_back(c);
        end
  endtask

  // Called #1 after a posedge: the next posedge is the start edge.
  task automatic start_stream(input map_t m);
    path = m;
    push_expected(m);
    valid_cycles = 0;
    done = 1'b1;
  endtask

  task automatic wait_finish(input int exp_count, input int exp_cycles, input bit rnd);
    int cyc;
    bit seen;
    cyc = 0;
    seen = 1'b0;
    while (cyc < 1000 && !seen) begin
      sif.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (finished) seen = 1'b1;
    end
    sif.out_ready = 1'b1;
    check("finish_seen", 32'(seen), 32'd1);
    if (seen) begin
      if (exp_cycles >= 0) check("finish_cycles", 32'(cyc - 1), 32'(exp_cycles));
      check("cell_count", 32'(cell_count), 32'(exp_count));
      check("missing_emits", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;
      check("finished_pulse_len", 32'(finished), 32'd0);
      check("idle_not_busy", 32'(busy), 32'd0);
    end
  endtask

  task automatic wait_valid(input string name);
    int cyc;
    cyc = 0;
    while (!sif.out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(name, 32'(sif.out_valid), 32'd1);
  endtask

  // Scoreboard: compare each accepted coordinate against the model queue.
  always @(negedge clk) begin
    cell_t e;
    if (!rst && sif.out_valid) begin
      valid_cycles++;
      if (sif.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_emit: got (%0d,%0d) expected no emission", sif.out_x, sif.out_y);
        end else begin
          e = exp_q.pop_front();
          check("emit_x", 32'(sif.out_x), 32'(e.x));
          check("emit_y", 32'(sif.out_y), 32'(e.y));
          check("emit_last", 32'(sif.out_last), 32'(e.last));
        end
      end
    end
  end

  initial begin
    map_t m2;
    map_t m3;
    n_cmp = 0;
    n_bad = 0;
    valid_cycles = 0;

    for (int i = 0; i < 6; i++) begin
      vecs[i].map = '0;
      vecs[i].rnd_ready = 1'b0;
    end
    vecs[0].map[0][4] = 1'b1; vecs[0].map[1][4] = 1'b1; vecs[0].map[2][4] = 1'b1;
    vecs[0].exp_count = 3;
    vecs[1].exp_count = 0;
    vecs[2].map[8][8] = 1'b1;
    vecs[2].exp_count = 1;
    vecs[3].map[0][0] = 1'b1; vecs[3].map[0][1] = 1'b1;
    vecs[3].exp_count = 2; vecs[3].rnd_ready = 1'b1;
    for (int i = 0; i < SIZE; i++) vecs[4].map[i][i] = 1'b1;
    vecs[4].exp_count = 9; vecs[4].rnd_ready = 1'b1;
    vecs[5].map = '1;
    vecs[5].exp_count = 81;
    m3 = vecs[0].map;
    m2 = vecs[3].map;

    rst = 1'b1;
    done = 1'b0;
    path = '0;
    sif.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(sif.out_valid), 32'd0);
    check("rst_x", 32'(sif.out_x), 32'd0);
    check("rst_y", 32'(sif.out_y), 32'd0);
    check("rst_last", 32'(sif.out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_finished", 32'(finished), 32'd0);
    check("rst_count", 32'(cell_count), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven streams.
    for (int i = 0; i < 6; i++) begin
      start_stream(vecs[i].map);
      wait_finish(vecs[i].exp_count, vecs[i].rnd_ready ? -1 : 81 + vecs[i].exp_count,
                  vecs[i].rnd_ready);
      if (!vecs[i].rnd_ready) check("valid_cycles", 32'(valid_cycles), 32'(vecs[i].exp_count));
      done = 1'b0;
      @(posedge clk); #1;
    end

    // Backpressure: first coordinate held stable for 5 stalled cycles.
    sif.out_ready = 1'b0;
    start_stream(m2);
    wait_valid("stall_valid_seen");
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 32'(sif.out_valid), 32'd1);
      check("stall_x", 32'(sif.out_x), 32'd0);
      check("stall_y", 32'(sif.out_y), 32'd0);
      check("stall_last", 32'(sif.out_last), 32'd0);
      @(posedge clk); #1;
    end
    wait_finish(2, -1, 1'b0);
    done = 1'b0;
    @(posedge clk); #1;

    // Reset during EMIT of the second of three cells, then full replay.
    sif.out_ready = 1'b0;
    start_stream(m3);
    wait_valid("mid_first_valid");
    sif.out_ready = 1'b1;
    @(posedge clk); #1;
    sif.out_ready = 1'b0;
    wait_valid("mid_second_valid");
    check("mid_second_y", 32'(sif.out_y), 32'd1);
    rst = 1'b1;
    done = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check("mid_rst_valid", 32'(sif.out_valid), 32'd0);
    check("mid_rst_x", 32'(sif.out_x), 32'd0);
    check("mid_rst_y", 32'(sif.out_y), 32'd0);
    check("mid_rst_last", 32'(sif.out_last), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_count", 32'(cell_count), 32'd0);
    rst = 1'b0;
    sif.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("post_rst_quiet", 32'(sif.out_valid | busy), 32'd0);
    end
    start_stream(m3);
    wait_finish(3, 84, 1'b0);

    // done held high after finishing must not restart; a fresh edge replays.
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      check("hold_no_restart", 32'(busy | sif.out_valid), 32'd0);
    end
    done = 1'b0;
    @(posedge clk); #1;
    start_stream(m3);
    wait_finish(3, 84, 1'b0);
    done = 1'b0;
    @(posedge clk); #1;

    // done held high through reset starts on the first cycle after release.
    rst = 1'b1;
    @(posedge clk); #1;
    start_stream(m3);
    @(posedge clk); #1;
    check("rst_hold_idle", 32'(busy), 32'd0);
    rst = 1'b0;
    wait_finish(3, 84, 1'b0);
    done = 1'b0;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
